// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key-event receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int unsigned SCAN_W     = 8;
  localparam int unsigned EVENT_W    = SCAN_W + 2;
  localparam int unsigned EV_REL_BIT = SCAN_W;
  localparam int unsigned EV_EXT_BIT = SCAN_W + 1;
  localparam int unsigned FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// Bit-level PS/2 receiver: synchronises the lines, assembles 11-bit frames,
// checks start/stop/odd parity and aborts stalled frames after a timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [SCAN_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              frame_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [SCAN_W-1:0]      byte_q, byte_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   ps2_clk_s, ps2_data_s, sample, frame_ok;

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = dat_sync_q[SYNC_STAGES-1];
  assign sample     = clk_prev_q & ~ps2_clk_s;
  // shift_q holds start in bit 0, data in [8:1], parity in bit 9; stop is live.
  assign frame_ok   = ~shift_q[0] & ps2_data_s & (^shift_q[9:1]);

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d = ps2_clk_s;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    to_cnt_d   = to_cnt_q;
    byte_d     = byte_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (sample) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
        bit_cnt_d = '0;
        if (frame_ok) begin
          byte_d  = shift_q[8:1];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {ps2_data_s, shift_q[9:1]};
      end
    end else if (bit_cnt_q != '0) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        err_d     = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      to_cnt_q   <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_byte    = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 key-event receiver: decodes E0/F0 prefixes into {ext, rel, scan}
// events and queues them in a small FIFO with sticky error flags.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          RELEASE_ONLY   = 1'b0
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic [EVENT_W-1:0]       key_event,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     frame_err,
  input  logic                     err_clear
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SCAN_W-1:0]  rx_byte;
  logic               byte_valid, rx_err;
  dec_state_e         state_q, state_d;
  logic               ev_valid, push_req, push, pop, full;
  logic [EVENT_W-1:0] ev_data;
  logic [EVENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d, ferr_q, ferr_d;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (rx_err)
  );

  always_comb begin
    state_d  = state_q;
    ev_valid = 1'b0;
    ev_data  = '0;
    if (byte_valid) begin
      if (rx_byte == PS2_EXT) begin
        state_d = ST_EXT;
      end else if (rx_byte == PS2_BRK) begin
        state_d = (state_q == ST_EXT || state_q == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
      end else begin
        ev_valid = 1'b1;
        ev_data  = {(state_q == ST_EXT || state_q == ST_EXT_BRK),
                    (state_q == ST_BRK || state_q == ST_EXT_BRK), rx_byte};
        state_d  = ST_IDLE;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push_req = ev_valid && (!RELEASE_ONLY || ev_data[EV_REL_BIT]);
    pop      = (count_q != '0) && out_ready;
    full     = (count_q == CNT_W'(DEPTH));
    push     = push_req && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d    = (push_req && full && !pop) ? 1'b1 : (err_clear ? 1'b0 : ovf_q);
    ferr_d   = rx_err ? 1'b1 : (err_clear ? 1'b0 : ferr_q);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ev_data;
  end

  assign out_valid = (count_q != '0);
  assign key_event = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule
